// File: rtl/core_fetch_s.sv
// core_fetch_s: Selen instruction-fetch stage; single-outstanding IL1 handshake,
// small {inst, pc} buffer toward decode, stall and redirect handling.
`timescale 1ns/1ps
module core_fetch_s #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_enb_in,
   input  logic        fetch_redirect_in,
   input  logic [31:0] fetch_redirect_pc_in,
   output logic        fetch_il1_req_out,
   output logic [31:0] fetch_il1_addr_out,
   input  logic        fetch_il1_ack_in,
   input  logic [31:0] fetch_il1_data_in,
   output logic [31:0] fetch_inst_out,
   output logic [31:0] fetch_pc_out,
   output logic [31:0] fetch_pc_4_out,
   output logic        fetch_vld_out,
   output logic        fetch_nop_gen_out,
   output logic        fetch_stall_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
   state_t state_q, state_d;
   logic [31:0] pc_q, pc_d, addr_q, addr_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic [31:0] inst_mem [FIFO_DEPTH];
   logic [31:0] pc_mem [FIFO_DEPTH];
   logic vld, push, pop;
   always_comb begin
      vld = cnt_q != '0;
      pop = vld & fetch_enb_in & ~fetch_redirect_in;
      push = (state_q == REQ) & fetch_il1_ack_in & ~fetch_redirect_in;
      wr_d = wr_q + AW'(push);
      rd_d = fetch_redirect_in ? wr_q : rd_q + AW'(pop);
      cnt_d = fetch_redirect_in ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      pc_d = push ? pc_q + 32'd4 : pc_q;
      state_d = state_q;
      if (fetch_redirect_in) begin
         pc_d = {fetch_redirect_pc_in[31:2], 2'b00};
         state_d = (state_q != IDLE && !fetch_il1_ack_in) ? DROP : REQ;
      end else if (state_q == IDLE || fetch_il1_ack_in) begin
         state_d = (cnt_d < DEPTH) ? REQ : IDLE;
      end
      // an abandoned request keeps its address on the bus until IL1 answers it
      addr_d = (state_d == DROP) ? addr_q : pc_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q <= RESET_PC;
         addr_q <= RESET_PC;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         addr_q <= addr_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_q] <= fetch_il1_data_in;
         pc_mem[wr_q] <= pc_q;
      end
   end
   assign fetch_il1_req_out = state_q != IDLE;
   assign fetch_il1_addr_out = addr_q;
   assign fetch_vld_out = vld;
   assign fetch_nop_gen_out = ~vld;
   assign fetch_inst_out = vld ? inst_mem[rd_q] : NOP_INST;
   assign fetch_pc_out = vld ? pc_mem[rd_q] : 32'd0;
   assign fetch_pc_4_out = fetch_pc_out + 32'd4;
   assign fetch_stall_out = (state_q != IDLE) & ~vld;
endmodule

// File: tb/tb_core_fetch_s.sv
// tb_core_fetch_s: directed vector table, reset corner cases, then randomized
// traffic against a transaction-level queue model of the fetch stage.
`timescale 1ns/1ps
module tb_core_fetch_s;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int DEPTH = 2;
   logic clk = 0, rst = 1;
   logic enb = 0, redir = 0, ack = 0;
   logic [31:0] rpc = 0, data = 0;
   logic req, vld, nop_gen, stall;
   logic [31:0] addr, inst, pc, pc_4;
   int n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   core_fetch_s dut (
      .clk(clk), .rst(rst),
      .fetch_enb_in(enb), .fetch_redirect_in(redir), .fetch_redirect_pc_in(rpc),
      .fetch_il1_req_out(req), .fetch_il1_addr_out(addr),
      .fetch_il1_ack_in(ack), .fetch_il1_data_in(data),
      .fetch_inst_out(inst), .fetch_pc_out(pc), .fetch_pc_4_out(pc_4),
      .fetch_vld_out(vld), .fetch_nop_gen_out(nop_gen), .fetch_stall_out(stall)
   );
   typedef struct {
      logic enb, redir;
      logic [31:0] rpc;
      logic ack;
      logic [31:0] data;
      logic req;
      logic [31:0] addr;
      logic vld;
      logic [31:0] pc, inst;
   } vec_t;
   vec_t tbl[$];
   typedef struct { logic [31:0] inst, pc; } ent_t;
   ent_t q[$];
   logic [31:0] m_pc, m_addr;
   logic m_req, m_drop;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_inst);
      chk({tag, " req"}, 32'(req), 32'(e_req));
      if (e_req) chk({tag, " addr"}, addr, e_addr);
      chk({tag, " vld"}, 32'(vld), 32'(e_vld));
      chk({tag, " nop_gen"}, 32'(nop_gen), 32'(!e_vld));
      chk({tag, " inst"}, inst, e_vld ? e_inst : NOP);
      chk({tag, " pc"}, pc, e_vld ? e_pc : 32'd0);
      chk({tag, " pc_4"}, pc_4, (e_vld ? e_pc : 32'd0) + 32'd4);
      chk({tag, " stall"}, 32'(stall), 32'(e_req && !e_vld));
   endtask
   task automatic add(input logic en, input logic rd, input logic [31:0] rp, input logic ak,
                      input logic [31:0] dt, input logic rq, input logic [31:0] ad,
                      input logic vl, input logic [31:0] p, input logic [31:0] in);
      tbl.push_back('{en, rd, rp, ak, dt, rq, ad, vl, p, in});
   endtask
   task automatic model_step(input logic en, input logic rd, input logic [31:0] rp,
                             input logic ak, input logic [31:0] dt);
      if (rd) begin
         q.delete();
         m_pc = {rp[31:2], 2'b00};
         if (m_req && !ak) m_drop = 1;
         else begin
            m_drop = 0;
            m_req = 1;
            m_addr = m_pc;
         end
      end else begin
         if (q.size() > 0 && en) void'(q.pop_front());
         if (m_req && ak) begin
            if (!m_drop) begin
               q.push_back('{dt, m_pc});
               m_pc = m_pc + 32'd4;
            end
            m_drop = 0;
            m_req = 0;
         end
         if (!m_req && q.size() < DEPTH) begin
            m_req = 1;
            m_addr = m_pc;
         end
      end
   endtask
   initial begin
      // redirect-to-FFFFFFFC covers pc wrap; rows 11-12 show a full buffer halting requests
      add(1,0,0,0,0,                 1,32'h0,        0,0,0);
      add(1,0,0,1,32'hA000_0000,     1,32'h4,        1,32'h0,32'hA000_0000);
      add(1,0,0,1,32'hA000_0001,     1,32'h8,        1,32'h4,32'hA000_0001);
      add(1,0,0,0,0,                 1,32'h8,        0,0,0);
      add(1,0,0,1,32'hA000_0002,     1,32'hC,        1,32'h8,32'hA000_0002);
      add(1,1,32'hFFFF_FFFF,0,0,     1,32'hC,        0,0,0);
      add(1,0,0,0,0,                 1,32'hC,        0,0,0);
      add(1,0,0,0,0,                 1,32'hC,        0,0,0);
      add(1,0,0,1,32'hDEAD_BEEF,     1,32'hFFFF_FFFC,0,0,0);
      add(1,0,0,1,32'hA000_0003,     1,32'h0,        1,32'hFFFF_FFFC,32'hA000_0003);
      add(0,0,0,0,0,                 1,32'h0,        1,32'hFFFF_FFFC,32'hA000_0003);
      add(0,0,0,1,32'hA000_0004,     0,32'h0,        1,32'hFFFF_FFFC,32'hA000_0003);
      add(0,0,0,0,0,                 0,32'h0,        1,32'hFFFF_FFFC,32'hA000_0003);
      add(1,0,0,0,0,                 1,32'h4,        1,32'h0,32'hA000_0004);
      add(1,1,32'h0000_0103,1,32'hBAD0_0BAD, 1,32'h100, 0,0,0);
      add(1,0,0,1,32'hA000_0005,     1,32'h104,      1,32'h100,32'hA000_0005);
      @(negedge clk);
      @(negedge clk);
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset addr", addr, 32'h0);
      rst = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         enb = tbl[i].enb; redir = tbl[i].redir; rpc = tbl[i].rpc;
         ack = tbl[i].ack; data = tbl[i].data;
         @(posedge clk);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].inst);
      end
      // asynchronous reset with a request outstanding and a valid head
      enb = 0; redir = 0; ack = 0;
      #2 rst = 1;
      #1 chk_out("async_rst", 0, 0, 0, 0, 0);
      @(negedge clk);
      chk_out("held_rst", 0, 0, 0, 0, 0);
      rst = 0; enb = 1;
      @(negedge clk);
      chk_out("rst_release", 1, 32'h0, 0, 0, 0);
      // randomized phase from a fresh reset
      rst = 1;
      @(negedge clk);
      rst = 0;
      q.delete(); m_pc = 0; m_addr = 0; m_req = 0; m_drop = 0;
      for (int c = 0; c < 3000; c++) begin
         chk_out("rand", m_req, m_addr, q.size() > 0,
                 q.size() > 0 ? q[0].pc : 32'd0, q.size() > 0 ? q[0].inst : NOP);
         enb = $urandom_range(0, 3) != 0;
         redir = $urandom_range(0, 15) == 0;
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         ack = m_req && $urandom_range(0, 1) == 1;
         data = $urandom;
         @(posedge clk);
         model_step(enb, redir, rpc, ack, data);
         @(negedge clk);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
